// File: rtl/apb_bcd_alu_slave.sv
// apb_bcd_alu_slave: APB slave fronting a digit-serial BCD/binary add/subtract engine.
// Revision 1.0
`default_nettype none

module apb_bcd_alu_slave #(
  parameter int DIGITS      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);
  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] WS   = 4'(WAIT_STATES);
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {BUS_IDLE = 2'd0, BUS_SETUP = 2'd1, BUS_ACCESS = 2'd2} bus_state_t;
  typedef enum logic [1:0] {ENG_IDLE = 2'd0, ENG_RUN = 2'd1, ENG_DONE = 2'd2} eng_state_t;

  bus_state_t bus_state, bus_next;
  eng_state_t eng_state, eng_next;
  logic [3:0]   wait_cnt, wait_cnt_next;
  logic         access, ready, err, wr_ok, start, start_req, mapped;
  logic [2:0]   idx;
  logic [31:0]  rdata;

  logic [W-1:0] opa, opb, result;
  logic [1:0]   mode;
  logic         cin, ie, carry, invalid, busy, done;

  logic [W-1:0] a_sh, b_sh, r_sh, r_next, dig_w;
  logic [1:0]   run_mode;
  logic         run_carry, run_inv;
  logic [3:0]   dcnt, da, db, dig;
  logic [4:0]   sum, diff;
  logic         cout, digit_bad, last_digit, inv_final;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bus_state <= BUS_IDLE;
      wait_cnt  <= '0;
    end else begin
      bus_state <= bus_next;
      wait_cnt  <= wait_cnt_next;
    end
  end

  always_comb begin
    bus_next      = bus_state;
    wait_cnt_next = '0;
    ready         = 1'b0;
    access        = PSEL && PENABLE;
    case (bus_state)
      BUS_IDLE: if (PSEL && !PENABLE) bus_next = BUS_SETUP;
      BUS_SETUP, BUS_ACCESS: begin
        if (!access) begin
          bus_next = (PSEL && !PENABLE) ? BUS_SETUP : BUS_IDLE;
        end else if (wait_cnt == WS) begin
          ready    = 1'b1;
          bus_next = BUS_IDLE;
        end else begin
          bus_next      = BUS_ACCESS;
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      default: bus_next = BUS_IDLE;
    endcase
  end

  assign busy = (eng_state == ENG_RUN);
  assign done = (eng_state == ENG_DONE);

  always_comb begin
    idx       = PADDR[4:2];
    mapped    = (PADDR[31:5] == 27'd0) && (idx <= 3'd4);
    start_req = PWRITE && (idx == 3'd2) && PWDATA[4];
    // A rejected write must leave every register and the engine untouched.
    err       = !mapped
             || (PWRITE && (idx == 3'd3 || idx == 3'd4))
             || (start_req && (busy || PWDATA[1:0] == 2'b11));
    wr_ok     = ready && PWRITE && !err;
    start     = wr_ok && start_req;
    case (idx)
      3'd0:    rdata = 32'(opa);
      3'd1:    rdata = 32'(opb);
      3'd2:    rdata = {28'd0, ie, cin, mode};
      3'd3:    rdata = 32'(result);
      3'd4:    rdata = {28'd0, invalid, carry, done, busy};
      default: rdata = '0;
    endcase
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && err;
  assign PRDATA  = (ready && !PWRITE && !err) ? rdata : '0;
  assign IRQ     = done && ie;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      opa  <= '0;
      opb  <= '0;
      mode <= '0;
      cin  <= 1'b0;
      ie   <= 1'b0;
    end else if (wr_ok) begin
      case (idx)
        3'd0: opa <= PWDATA[W-1:0];
        3'd1: opb <= PWDATA[W-1:0];
        3'd2: begin
          mode <= PWDATA[1:0];
          cin  <= PWDATA[2];
          ie   <= PWDATA[3];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) eng_state <= ENG_IDLE;
    else        eng_state <= eng_next;
  end

  always_comb begin
    eng_next = eng_state;
    case (eng_state)
      ENG_IDLE, ENG_DONE: if (start) eng_next = ENG_RUN;
      ENG_RUN:            if (last_digit) eng_next = ENG_DONE;
      default:            eng_next = ENG_IDLE;
    endcase
  end

  // One digit slice per cycle; the carry/borrow ripples through run_carry.
  always_comb begin
    da        = a_sh[3:0];
    db        = b_sh[3:0];
    sum       = {1'b0, da} + {1'b0, db} + {4'd0, run_carry};
    diff      = {1'b0, da} - {1'b0, db} - {4'd0, run_carry};
    dig       = sum[3:0];
    cout      = sum[4];
    case (run_mode)
      2'b00: begin
        cout = (sum > 5'd9);
        dig  = cout ? 4'(sum - 5'd10) : sum[3:0];
      end
      2'b01: begin
        cout = diff[4];
        dig  = cout ? 4'(diff + 5'd10) : diff[3:0];
      end
      default: ;
    endcase
    digit_bad  = (run_mode != 2'b10) && (da > 4'd9 || db > 4'd9);
    last_digit = (dcnt == LAST);
    inv_final  = run_inv || digit_bad;
    dig_w      = '0;
    dig_w[3:0] = dig;
    r_next     = (r_sh >> 4) | (dig_w << (W - 4));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      run_mode  <= '0;
      run_carry <= 1'b0;
      run_inv   <= 1'b0;
      dcnt      <= '0;
      result    <= '0;
      carry     <= 1'b0;
      invalid   <= 1'b0;
    end else if (start) begin
      a_sh      <= opa;
      b_sh      <= opb;
      r_sh      <= '0;
      run_mode  <= PWDATA[1:0];
      run_carry <= PWDATA[2];
      run_inv   <= 1'b0;
      dcnt      <= '0;
      carry     <= 1'b0;
      invalid   <= 1'b0;
    end else if (busy) begin
      a_sh      <= a_sh >> 4;
      b_sh      <= b_sh >> 4;
      r_sh      <= r_next;
      run_carry <= cout;
      run_inv   <= inv_final;
      dcnt      <= dcnt + 4'd1;
      if (last_digit) begin
        invalid <= inv_final;
        result  <= inv_final ? '0 : r_next;
        carry   <= !inv_final && cout;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_bcd_alu_slave.sv
// tb_apb_bcd_alu_slave: scoreboard bench with a decimal-arithmetic reference model.
// Revision 1.0
`default_nettype none

module tb_apb_bcd_alu_slave;
  localparam int     DIGITS      = 8;
  localparam int     WAIT_STATES = 1;
  localparam longint MOD10       = 64'd100000000;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, IRQ;

  int errors = 0;
  int checks = 0;
  int waits  = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_opa, m_opb, m_result, p_res;
  logic [1:0]  m_mode;
  logic        m_cin, m_ie, m_carry, m_inv, m_done, p_carry, p_inv;

  apb_bcd_alu_slave #(.DIGITS(DIGITS), .WAIT_STATES(WAIT_STATES)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit has_bad(input logic [31:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint from_bcd(input logic [31:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint x);
    logic [31:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                       input logic cin, output logic [31:0] res, output logic cy, output logic inv);
    longint      x;
    logic [32:0] bs;
    inv = (mode != 2'b10) && (has_bad(a) || has_bad(b));
    res = '0;
    cy  = 1'b0;
    if (!inv) begin
      case (mode)
        2'b00: begin
          x   = from_bcd(a) + from_bcd(b) + longint'(cin);
          cy  = (x >= MOD10);
          res = to_bcd(x % MOD10);
        end
        2'b01: begin
          x  = from_bcd(a) - from_bcd(b) - longint'(cin);
          cy = (x < 0);
          if (x < 0) x = x + MOD10;
          res = to_bcd(x);
        end
        default: begin
          bs  = {1'b0, a} + {1'b0, b} + 33'(cin);
          res = bs[31:0];
          cy  = bs[32];
        end
      endcase
    end
  endtask

  function automatic logic [31:0] ctrl_exp();
    return {28'd0, m_ie, m_cin, m_mode};
  endfunction

  function automatic logic [31:0] status_exp(input logic busy);
    return {28'd0, m_inv, m_carry, m_done, busy};
  endfunction

  // Monitor: pops one expectation per completed transfer.
  always @(negedge PCLK) begin : monitor
    exp_t e;
    if (!PRESET && PSEL && PENABLE) begin
      if (!PREADY) begin
        waits++;
        check("wait_prdata", PRDATA, 32'd0);
        check("wait_pslverr", 32'(PSLVERR), 32'd0);
      end else begin
        check("wait_states", 32'(waits), 32'(WAIT_STATES));
        waits = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got completion with no expectation queued");
        end else begin
          e = sb.pop_front();
          check({e.name, "_prdata"}, PRDATA, e.data);
          check({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.err));
        end
      end
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_err, input string name);
    int k;
    sb.push_back('{name, exp_data, exp_err});
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    k = 0;
    do begin
      @(negedge PCLK);
      k++;
    end while (!PREADY && k < 40);
    if (!PREADY) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: PREADY low for %0d cycles, required high within 40", name, k);
      void'(sb.pop_back());
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic err, input string name);
    apb(1'b1, addr, data, 32'd0, err, name);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic err, input string name);
    apb(1'b0, addr, 32'd0, exp, err, name);
  endtask

  task automatic model_reset();
    m_opa = '0; m_opb = '0; m_result = '0; m_mode = '0;
    m_cin = 1'b0; m_ie = 1'b0; m_carry = 1'b0; m_inv = 1'b0; m_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pready"}, 32'(PREADY), 32'd0);
    check({tag, "_pslverr"}, 32'(PSLVERR), 32'd0);
    check({tag, "_prdata"}, PRDATA, 32'd0);
    check({tag, "_irq"}, 32'(IRQ), 32'd0);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                          input logic cin, input logic ie);
    wr(32'h00, a, 1'b0, "wr_opa");
    m_opa = a;
    wr(32'h04, b, 1'b0, "wr_opb");
    m_opb = b;
    m_mode = mode; m_cin = cin; m_ie = ie; m_done = 1'b0;
    model(m_opa, m_opb, mode, cin, p_res, p_carry, p_inv);
    wr(32'h08, {27'd0, 1'b1, ie, cin, mode}, 1'b0, "wr_ctrl_start");
  endtask

  task automatic finish_op(input bit timed);
    int k;
    if (timed && m_ie) begin
      k = 0;
      do begin
        @(negedge PCLK);
        k++;
      end while (!IRQ && k < 60);
      check("irq_latency", 32'(k), 32'(DIGITS + 1));
    end else begin
      repeat (DIGITS + 2) @(posedge PCLK);
    end
    m_result = p_res; m_carry = p_carry; m_inv = p_inv; m_done = 1'b1;
    rd(32'h0C, m_result, 1'b0, "rd_result");
    rd(32'h10, status_exp(1'b0), 1'b0, "rd_status");
    check("irq_level", 32'(IRQ), 32'(m_ie && m_done));
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                       input logic cin, input logic ie);
    start_op(a, b, mode, cin, ie);
    finish_op(1'b1);
  endtask

  task automatic read_all(input string tag);
    rd(32'h00, m_opa, 1'b0, {tag, "_opa"});
    rd(32'h04, m_opb, 1'b0, {tag, "_opb"});
    rd(32'h08, ctrl_exp(), 1'b0, {tag, "_ctrl"});
    rd(32'h0C, m_result, 1'b0, {tag, "_result"});
    rd(32'h10, status_exp(1'b0), 1'b0, {tag, "_status"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  mode;
    logic        cin;
    int          p;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    model_reset();
    p_res = '0; p_carry = 1'b0; p_inv = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_reset_outputs("reset");
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    read_all("after_reset");

    // BCD add with carry propagation; status and result read while running.
    start_op(32'h00000309, 32'h30000003, 2'b00, 1'b0, 1'b0);
    rd(32'h10, status_exp(1'b1), 1'b0, "rd_status_busy");
    rd(32'h0C, m_result, 1'b0, "rd_result_busy");
    finish_op(1'b0);
    rd(32'h08, ctrl_exp(), 1'b0, "rd_ctrl_start_reads0");

    do_op(32'h99999999, 32'h00000001, 2'b00, 1'b0, 1'b1);
    repeat (5) @(posedge PCLK);
    #1 check("irq_held", 32'(IRQ), 32'd1);

    do_op(32'h00000100, 32'h00000001, 2'b01, 1'b0, 1'b1);
    do_op(32'h00000001, 32'h00000002, 2'b01, 1'b0, 1'b1);
    do_op(32'h0000000C, 32'h00000001, 2'b00, 1'b0, 1'b1);
    do_op(32'h0000000C, 32'h00000001, 2'b10, 1'b0, 1'b1);

    // Rejected accesses.
    rd(32'h14, 32'd0, 1'b1, "rd_unmapped_14");
    rd(32'h20, 32'd0, 1'b1, "rd_unmapped_20");
    rd(32'h100, 32'd0, 1'b1, "rd_unmapped_100");
    rd(32'h03, m_opa, 1'b0, "rd_opa_lowbits");
    wr(32'h0C, 32'h12345678, 1'b1, "wr_result_ro");
    wr(32'h10, 32'h0000000F, 1'b1, "wr_status_ro");
    wr(32'h14, 32'h0000000F, 1'b1, "wr_unmapped");
    wr(32'h08, 32'h00000013, 1'b1, "wr_start_mode3");
    read_all("after_errors");
    check("irq_after_errors", 32'(IRQ), 32'(m_ie && m_done));

    start_op(32'h12345678, 32'h11111111, 2'b01, 1'b1, 1'b1);
    wr(32'h08, 32'h00000010, 1'b1, "wr_start_busy");
    rd(32'h10, status_exp(1'b1), 1'b0, "rd_status_run");
    finish_op(1'b0);
    rd(32'h08, ctrl_exp(), 1'b0, "rd_ctrl_after_busy_start");

    start_op(32'h00000555, 32'h00000445, 2'b00, 1'b0, 1'b1);
    wr(32'h00, 32'h55555555, 1'b0, "wr_opa_run");
    m_opa = 32'h55555555;
    rd(32'h0C, m_result, 1'b0, "rd_result_run");
    finish_op(1'b0);
    rd(32'h00, m_opa, 1'b0, "rd_opa_after_run");

    // Asynchronous reset while IRQ is high, with no clock edge in between.
    @(posedge PCLK); #3;
    PRESET = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
    read_all("after_async_reset");

    // Reset in the middle of a run.
    start_op(32'h00000123, 32'h00000456, 2'b00, 1'b0, 1'b1);
    repeat (4) @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1 check_reset_outputs("mid_run_reset");
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
    repeat (DIGITS + 2) @(posedge PCLK);
    read_all("after_mid_run_reset");
    do_op(32'h00012345, 32'h00054321, 2'b00, 1'b1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      mode = 2'($urandom_range(0, 2));
      cin  = 1'($urandom_range(0, 1));
      if (mode == 2'b10) begin
        a = $urandom;
        b = $urandom;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          a[4*d +: 4] = 4'($urandom_range(0, 9));
          b[4*d +: 4] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 5) == 0) begin
          p = $urandom_range(0, DIGITS - 1);
          b[4*p +: 4] = 4'($urandom_range(10, 15));
        end
      end
      do_op(a, b, mode, cin, 1'b1);
      rd(32'h08, ctrl_exp(), 1'b0, "rd_ctrl_rand");
    end

    repeat (2) @(posedge PCLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
